// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl: sequencer in front of the 8-8-4 BNN datapath.
// Turns a byte-wide weight stream into the datapath's two-cycle nibble-load
// protocol (low nibble, then high nibble), rewinds the datapath write pointer
// with a one-cycle dp_rst pulse, and runs one inference at a time, waiting
// out the datapath pipeline before returning the 4-bit result.
//
// Handshakes (cfg_*, in_*, out_*): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds valid and data
// stable until the transfer; ready may depend combinationally on valid of
// another channel, never on its own valid. out_valid/out_data stay stable
// until out_valid && out_ready.
module bnn_seq_ctrl #(
    parameter int NUM_NEURONS = 12,
    parameter int PIPE_LAT    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_data,
    input  logic       cfg_restart,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic [7:0] dp_x,
    output logic [3:0] dp_wnib,
    output logic       dp_load_en,
    output logic       dp_rst,
    input  logic [3:0] dp_y,
    output logic [3:0] loaded_cnt,
    output logic       cfg_done,
    output logic [2:0] dbg_state
);

    // Run counter wide enough to count 0..PIPE_LAT.
    localparam int CW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_LO = 3'd1,
        ST_LOAD_HI = 3'd2,
        ST_REWIND  = 3'd3,
        ST_RUN     = 3'd4,
        ST_RESULT  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_byte;
    logic [7:0]      r_dp_x;
    logic [CW-1:0]   r_run_cnt;
    logic [3:0]      r_loaded_cnt;
    logic            r_out_valid;
    logic [3:0]      r_out_data;
    logic            w_cfg_take;
    logic            w_in_take;
    logic            w_run_last;
    logic            w_cfg_done;

    assign w_cfg_done = (r_loaded_cnt == 4'(NUM_NEURONS));
    assign w_cfg_take = cfg_valid && cfg_ready;
    assign w_in_take  = in_valid && in_ready;
    assign w_run_last = (r_run_cnt == CW'(PIPE_LAT));

    // Handshake readiness: only IDLE accepts; restart beats cfg beats inference.
    always_comb begin
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        if (r_state == ST_IDLE) begin
            cfg_ready = !w_cfg_done && !cfg_restart;
            in_ready  = !cfg_restart && !(cfg_valid && !w_cfg_done);
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_restart)     w_next = ST_REWIND;
                else if (w_cfg_take) w_next = ST_LOAD_LO;
                else if (w_in_take)  w_next = ST_RUN;
            end
            ST_LOAD_LO: w_next = ST_LOAD_HI;
            ST_LOAD_HI: w_next = ST_IDLE;
            ST_REWIND:  w_next = ST_IDLE;
            ST_RUN:     if (w_run_last) w_next = ST_RESULT;
            ST_RESULT:  if (out_ready) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Datapath-facing strobes decoded from the current state.
    always_comb begin
        dp_load_en = 1'b0;
        dp_wnib    = 4'h0;
        dp_rst     = 1'b0;
        case (r_state)
            ST_LOAD_LO: begin
                dp_load_en = 1'b1;
                dp_wnib    = r_byte[3:0];
            end
            ST_LOAD_HI: begin
                dp_load_en = 1'b1;
                dp_wnib    = r_byte[7:4];
            end
            ST_REWIND: dp_rst = 1'b1;
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Latch the accepted weight byte and the accepted input vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte <= 8'h00;
            r_dp_x <= 8'h00;
        end else begin
            if (w_cfg_take) r_byte <= cfg_data;
            if (w_in_take)  r_dp_x <= in_data;
        end
    end

    // Count pipeline cycles while an inference is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  r_run_cnt <= '0;
        else if (w_in_take)                         r_run_cnt <= '0;
        else if (r_state == ST_RUN && !w_run_last)  r_run_cnt <= r_run_cnt + 1'b1;
    end

    // Neurons-written counter: cleared by rewind, saturating at NUM_NEURONS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     r_loaded_cnt <= 4'h0;
        else if (r_state == ST_REWIND) r_loaded_cnt <= 4'h0;
        else if (r_state == ST_LOAD_HI && !w_cfg_done)
                                       r_loaded_cnt <= r_loaded_cnt + 4'h1;
    end

    // Capture the datapath result at the end of RUN; hold it until popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 4'h0;
        end else if (r_state == ST_RUN && w_run_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= dp_y;
        end else if (r_state == ST_RESULT && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign dp_x       = r_dp_x;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign loaded_cnt = r_loaded_cnt;
    assign cfg_done   = w_cfg_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Bench for bnn_seq_ctrl: a small stand-in datapath (nibble loader plus a
// 2-stage registered parity network) sits behind the sequencer, and results
// are checked against a reference built from the weight bytes the bench sent.
module tb_bnn_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid, cfg_ready, cfg_restart;
    logic [7:0] cfg_data;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_ready;
    logic [3:0] out_data;
    logic [7:0] dp_x;
    logic [3:0] dp_wnib;
    logic       dp_load_en, dp_rst;
    logic [3:0] dp_y;
    logic [3:0] loaded_cnt;
    logic       cfg_done;
    logic [2:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // Reference: weight bytes by neuron index, as written by the bench.
    logic [7:0] ref_w [12];
    int         ref_cnt;

    bnn_seq_ctrl #(.NUM_NEURONS(12), .PIPE_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .cfg_restart(cfg_restart),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .dp_x(dp_x), .dp_wnib(dp_wnib), .dp_load_en(dp_load_en), .dp_rst(dp_rst),
        .dp_y(dp_y), .loaded_cnt(loaded_cnt), .cfg_done(cfg_done),
        .dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Stand-in datapath: weight memory loaded low nibble then high nibble.
    logic [7:0] m_w [12];
    logic [3:0] m_lo;
    logic       m_ph;
    int         m_ptr;
    logic [7:0] m_s1;

    always @(posedge clk or posedge reset) begin
        if (reset || dp_rst) begin
            for (int i = 0; i < 12; i++) m_w[i] <= 8'h00;
            m_lo  <= 4'h0;
            m_ph  <= 1'b0;
            m_ptr <= 0;
        end else if (dp_load_en) begin
            if (!m_ph) begin
                m_lo <= dp_wnib;
                m_ph <= 1'b1;
            end else begin
                if (m_ptr < 12) m_w[m_ptr] <= {dp_wnib, m_lo};
                m_ptr <= m_ptr + 1;
                m_ph  <= 1'b0;
            end
        end
    end

    // Stand-in datapath: two register stages from dp_x to dp_y.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 <= 8'h00;
            dp_y <= 4'h0;
        end else begin
            m_s1 <= dp_x;
            for (int k = 0; k < 4; k++)
                dp_y[k] <= (^(m_s1 & m_w[8+k])) ^ (^m_w[2*k]) ^ (^m_w[2*k+1]);
        end
    end

    // Expected result from the bytes sent, using counting arithmetic.
    function automatic logic [3:0] ref_y(input logic [7:0] x);
        logic [3:0] y;
        int         s;
        for (int k = 0; k < 4; k++) begin
            s = $countones(x & ref_w[8+k]) + $countones(ref_w[2*k]) + $countones(ref_w[2*k+1]);
            y[k] = (s % 2) == 1;
        end
        return y;
    endfunction

    task automatic clear_ref();
        for (int i = 0; i < 12; i++) ref_w[i] = 8'h00;
        ref_cnt = 0;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push one weight byte and follow its three cycles.
    task automatic load_byte(input logic [7:0] b);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_data  = b;
        #1;
        check("ld_cfg_ready", 8'(cfg_ready), 8'd1);
        check("ld_in_ready", 8'(in_ready), 8'd0);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("ld_lo_en", 8'(dp_load_en), 8'd1);
        check("ld_lo_nib", 8'(dp_wnib), 8'(b[3:0]));
        @(negedge clk);
        check("ld_hi_en", 8'(dp_load_en), 8'd1);
        check("ld_hi_nib", 8'(dp_wnib), 8'(b[7:4]));
        ref_w[ref_cnt] = b;
        ref_cnt++;
        @(negedge clk);
        check("ld_en_off", 8'(dp_load_en), 8'd0);
        check("ld_cnt", 8'(loaded_cnt), 8'(ref_cnt));
    endtask

    // One inference; result held for 'hold' cycles before the pop.
    // With pend set, the next request is already offered during the run.
    task automatic do_infer(input logic [7:0] x, input int hold,
                            input logic pend, input logic [7:0] nxt);
        logic [3:0] exp;
        exp = ref_y(x);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        #1;
        check("inf_in_ready", 8'(in_ready), 8'd1);
        @(posedge clk);
        #1;
        in_valid = pend;
        in_data  = nxt;
        for (int c = 0; c < 3; c++) begin
            check("inf_run_ov", 8'(out_valid), 8'd0);
            check("inf_dp_x", dp_x, x);
            check("inf_run_irdy", 8'(in_ready), 8'd0);
            @(posedge clk);
            #1;
        end
        check("inf_ov", 8'(out_valid), 8'd1);
        check("inf_data", 8'(out_data), 8'(exp));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_ov", 8'(out_valid), 8'd1);
            check("hold_data", 8'(out_data), 8'(exp));
            check("hold_irdy", 8'(in_ready), 8'd0);
            check("hold_crdy", 8'(cfg_ready), 8'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pop_ov", 8'(out_valid), 8'd0);
        check("pop_data", 8'(out_data), 8'(exp));
        check("pop_dp_x", dp_x, x);
        check("pop_irdy", 8'(in_ready), 8'd1);
        out_ready = 1'b0;
        if (!pend) in_valid = 1'b0;
    endtask

    // Per-cycle vector for the table-driven 12-byte stream.
    typedef struct {
        logic       cv;
        logic [7:0] cd;
        logic       e_crdy;
        logic       e_irdy;
        logic       e_en;
        logic [3:0] e_wnib;
        logic [3:0] e_cnt;
        logic       e_done;
    } vec_t;

    vec_t tbl [39];

    function automatic vec_t mk(input logic cv, input logic [7:0] cd, input logic crdy,
                                input logic irdy, input logic en, input logic [3:0] nib,
                                input logic [3:0] cnt, input logic done);
        vec_t v;
        v.cv = cv; v.cd = cd; v.e_crdy = crdy; v.e_irdy = irdy;
        v.e_en = en; v.e_wnib = nib; v.e_cnt = cnt; v.e_done = done;
        return v;
    endfunction

    initial begin
        logic [7:0] b;

        // Fill the table: three cycles per byte, then a stalled 13th byte.
        for (int i = 0; i < 12; i++) begin
            b = 8'(i + 1);
            tbl[3*i]   = mk(1'b1, b, 1'b1, 1'b0, 1'b0, 4'h0,   4'(i), 1'b0);
            tbl[3*i+1] = mk(1'b1, b, 1'b0, 1'b0, 1'b1, b[3:0], 4'(i), 1'b0);
            tbl[3*i+2] = mk(1'b1, b, 1'b0, 1'b0, 1'b1, b[7:4], 4'(i), 1'b0);
        end
        for (int i = 36; i < 39; i++)
            tbl[i] = mk(1'b1, 8'h0D, 1'b0, 1'b1, 1'b0, 4'h0, 4'd12, 1'b1);

        // Reset.
        reset = 1'b1;
        cfg_valid = 1'b0; cfg_data = 8'h00; cfg_restart = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        clear_ref();
        #1;
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_out_data", 8'(out_data), 8'd0);
        check("rst_dp_x", dp_x, 8'd0);
        check("rst_load_en", 8'(dp_load_en), 8'd0);
        check("rst_dp_rst", 8'(dp_rst), 8'd0);
        check("rst_loaded_cnt", 8'(loaded_cnt), 8'd0);
        check("rst_cfg_done", 8'(cfg_done), 8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_crdy", 8'(cfg_ready), 8'd1);
        check("post_rst_irdy", 8'(in_ready), 8'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_load_en", 8'(dp_load_en), 8'd0);
            check("idle_wnib", 8'(dp_wnib), 8'd0);
        end

        // Default weights: result must be the all-zero pattern.
        do_infer(8'hFF, 0, 1'b0, 8'h00);

        // Table-driven 12-byte stream with cfg_valid held.
        for (int j = 0; j < 39; j++) begin
            @(negedge clk);
            cfg_valid = tbl[j].cv;
            cfg_data  = tbl[j].cd;
            #1;
            check("tbl_crdy", 8'(cfg_ready), 8'(tbl[j].e_crdy));
            check("tbl_irdy", 8'(in_ready), 8'(tbl[j].e_irdy));
            check("tbl_en", 8'(dp_load_en), 8'(tbl[j].e_en));
            check("tbl_wnib", 8'(dp_wnib), 8'(tbl[j].e_wnib));
            check("tbl_cnt", 8'(loaded_cnt), 8'(tbl[j].e_cnt));
            check("tbl_done", 8'(cfg_done), 8'(tbl[j].e_done));
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int i = 0; i < 12; i++) ref_w[i] = 8'(i + 1);
        ref_cnt = 12;

        // Back-to-back requests with a long hold on the first result.
        do_infer(8'h0F, 5, 1'b1, 8'hF0);
        do_infer(8'hF0, 5, 1'b0, 8'h00);

        // Random inferences on the loaded weights.
        for (int r = 0; r < 8; r++)
            do_infer(8'($urandom_range(0, 255)), $urandom_range(0, 3), 1'b0, 8'h00);

        // Rewind: one-cycle dp_rst, counters cleared.
        @(negedge clk);
        cfg_restart = 1'b1;
        #1;
        check("rw_crdy", 8'(cfg_ready), 8'd0);
        check("rw_irdy", 8'(in_ready), 8'd0);
        @(negedge clk);
        cfg_restart = 1'b0;
        check("rw_dp_rst", 8'(dp_rst), 8'd1);
        @(negedge clk);
        check("rw_dp_rst_off", 8'(dp_rst), 8'd0);
        check("rw_cnt", 8'(loaded_cnt), 8'd0);
        check("rw_done", 8'(cfg_done), 8'd0);
        clear_ref();
        do_infer(8'hA5, 1, 1'b0, 8'h00);

        // Random 12-byte reload, then random inferences.
        for (int i = 0; i < 12; i++) load_byte(8'($urandom_range(0, 255)));
        @(negedge clk);
        check("reload_done", 8'(cfg_done), 8'd1);
        check("reload_crdy", 8'(cfg_ready), 8'd0);
        for (int r = 0; r < 8; r++)
            do_infer(8'($urandom_range(0, 255)), $urandom_range(0, 2), 1'b0, 8'h00);

        // Restart, cfg byte and request all offered at once in IDLE.
        @(negedge clk);
        cfg_restart = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h5A; in_valid = 1'b1; in_data = 8'h33;
        #1;
        check("sim_crdy", 8'(cfg_ready), 8'd0);
        check("sim_irdy", 8'(in_ready), 8'd0);
        @(negedge clk);
        cfg_restart = 1'b0;
        check("sim_dp_rst", 8'(dp_rst), 8'd1);
        check("sim_rw_irdy", 8'(in_ready), 8'd0);
        @(negedge clk);
        check("sim_cnt0", 8'(loaded_cnt), 8'd0);
        check("sim_crdy2", 8'(cfg_ready), 8'd1);
        check("sim_irdy2", 8'(in_ready), 8'd0);
        @(negedge clk);
        cfg_valid = 1'b0; in_valid = 1'b0;
        check("sim_lo_en", 8'(dp_load_en), 8'd1);
        check("sim_lo_nib", 8'(dp_wnib), 8'hA);
        @(negedge clk);
        check("sim_hi_nib", 8'(dp_wnib), 8'h5);

        // Reset during LOAD_HI: outputs clear immediately.
        reset = 1'b1;
        #1;
        check("mid_rst_en", 8'(dp_load_en), 8'd0);
        check("mid_rst_nib", 8'(dp_wnib), 8'd0);
        check("mid_rst_dp_x", dp_x, 8'd0);
        check("mid_rst_cnt", 8'(loaded_cnt), 8'd0);
        check("mid_rst_ov", 8'(out_valid), 8'd0);
        check("mid_rst_od", 8'(out_data), 8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_ref();
        #1;
        check("after_rst_crdy", 8'(cfg_ready), 8'd1);
        do_infer(8'hC3, 0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bnn_seq_ctrl.md
Name: bnn_seq_ctrl

Overview:
Sequencer in front of the 8-8-4 BNN datapath (12 neurons, 8-bit weights, 2-stage registered layers). It turns a byte-wide weight stream into the datapath's two-cycle nibble-load protocol, then schedules inference requests. Inference runs one at a time: it drives the input vector, waits out the pipeline latency and returns the 4-bit result over a valid/ready handshake. It also re-arms the datapath's write pointer with a datapath reset pulse.

Parameters:
NUM_NEURONS, 12, weight bytes per full load; neuron index = byte order.
PIPE_LAT, 2, datapath register stages from input vector to output register.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
cfg_valid  in  1  weight byte offered
cfg_ready  out  1  weight byte accepted when high with cfg_valid
cfg_data  in  8  weight byte, bit7..bit0 = weight bits 7..0
cfg_restart  in  1  request to rewind the datapath (restores default weights)
in_valid  in  1  inference request
in_ready  out  1  request accepted when high with in_valid
in_data  in  8  input vector
out_valid  out  1  result available
out_ready  in  1  result consumed
out_data  out  4  neuron outputs 3..0
dp_x  out  8  datapath input vector
dp_wnib  out  4  datapath weight nibble
dp_load_en  out  1  datapath load strobe
dp_rst  out  1  datapath reset pulse
dp_y  in  4  datapath registered outputs
loaded_cnt  out  4  neurons written since last rewind
cfg_done  out  1  loaded_cnt == NUM_NEURONS

Behaviour:
- Reset: state IDLE. All outputs 0, including dp_x, out_data and loaded_cnt. Internal byte buffer 0.
- States: IDLE, LOAD_LO, LOAD_HI, REWIND, RUN, RESULT.
- IDLE handshake readiness:
  - cfg_ready = (state==IDLE) && !cfg_done && !cfg_restart.
  - in_ready = (state==IDLE) && !cfg_restart && !(cfg_valid && cfg_ready).
- IDLE priority: cfg_restart > cfg byte > inference. Only one event is taken per cycle.
- Rewind: cfg_restart in IDLE -> REWIND.
  - REWIND lasts 1 cycle with dp_rst=1.
  - On exit: loaded_cnt<=0, cfg_done<=0, return to IDLE.
  - cfg_restart in any other state is ignored; it is not latched.
- Weight load: a cfg byte accepted at edge E latches the byte.
  - Cycle after E = LOAD_LO: dp_load_en=1, dp_wnib=byte[3:0].
  - Next cycle = LOAD_HI: dp_load_en=1, dp_wnib=byte[7:4].
  - Exit LOAD_HI: loaded_cnt++, return to IDLE.
  - One byte costs 3 cycles. dp_load_en is never high outside LOAD_LO/LOAD_HI. dp_wnib is 0 when not loading.
- Overflow: once loaded_cnt==NUM_NEURONS, cfg_ready stays low until a rewind. No write is ever issued past neuron NUM_NEURONS-1. loaded_cnt saturates and never wraps.
- Inference: request accepted at edge E0 -> dp_x<=in_data at E0, enter RUN with cnt=0.
  - RUN lasts PIPE_LAT+1 cycles.
  - At edge E0+PIPE_LAT+1: out_data<=dp_y, out_valid<=1, state RESULT.
- Inference is allowed with cfg_done=0; partial or default weights are used as-is.
- dp_x holds its last value outside RUN.
- RESULT: out_valid and out_data are stable until out_valid&&out_ready. On that edge out_valid<=0 and state returns to IDLE; out_data keeps its value.
  - No new request or cfg is accepted in RESULT, so the next acceptance is at least 1 cycle after the pop.
- Asynchronous reset mid-load or mid-run aborts immediately, with no partial-write cleanup. The datapath shares the system reset, so both pointers return to 0 together.

Test Plan:
- Reset then idle -> all outputs 0; cfg_ready=1 and in_ready=1 in the first post-reset cycle; dp_load_en never toggles.
- Stream 12 bytes 0x01..0x0C with cfg_valid held -> per byte, dp_wnib=low nibble then high nibble with dp_load_en=1 for exactly 2 cycles; accepts spaced 3 cycles apart; cfg_done=1, loaded_cnt=12; 13th byte stalls with cfg_ready=0.
- Default weights, in_data=0xFF, out_ready=1 -> out_valid rises 3 cycles after acceptance with out_data = dp_y sampled (model: 4'b0000 for defaults; compare against reference model).
- Back-to-back requests 0x0F, 0xF0 with out_ready held low for 5 cycles -> out_valid and out_data stay stable; in_ready=0 until the pop; second result correct.
- Load 12 bytes, pulse cfg_restart -> exactly one cycle dp_rst=1; loaded_cnt=0, cfg_done=0; a 12-byte load is accepted again.
- Simultaneous cfg_valid, in_valid and cfg_restart in IDLE -> restart taken. Next cycle cfg byte taken, and in_ready stays 0 while cfg_valid is pending. Assert reset during LOAD_HI -> outputs 0 within the same cycle.
